// File: rtl/mouse_fmt_pkg.sv
// Shared constants, line length, hex helper and FSM state type for the
// mouse packet text formatter.
// MOUSE_FMT_CRLF_EN: when defined, lines end in CR LF (13 bytes).
// Otherwise they end in LF only (12 bytes).
package mouse_fmt_pkg;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_DASH  = 8'h2D;
    localparam logic [7:0] CH_L     = 8'h4C;
    localparam logic [7:0] CH_M     = 8'h4D;
    localparam logic [7:0] CH_R     = 8'h52;

`ifdef MOUSE_FMT_CRLF_EN
    localparam int LINE_LEN = 13;
`else
    localparam int LINE_LEN = 12;
`endif

    // The byte index is 4 bits wide, so some index values are never used.
    localparam int              IDX_W    = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Convert one nibble to an uppercase ASCII hex digit.
    // 0x37 + 10 = 0x41 ('A').
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/mouse_uart_fmt.sv
// Turns decoded PS/2 mouse packets into fixed-length ASCII lines of the form
// "LMR XXX YYY<term>" and writes them, one byte at a time, into the UART
// transmit FIFO. Packets that arrive while a line is still being sent are
// dropped and counted.
// MOUSE_FMT_CRLF_EN: when defined, <term> is CR LF. Otherwise it is LF only.
module mouse_uart_fmt
    import mouse_fmt_pkg::*;
#(
    parameter int DROP_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [8:0]        xm_i,
    input  logic [8:0]        ym_i,
    input  logic [2:0]        btnm_i,
    input  logic              m_done_tick_i,
    input  logic              tx_full_i,
    output logic [7:0]        w_data_o,
    output logic              wr_uart_o,
    output logic              busy_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [8:0]        x_q;
    logic [8:0]        y_q;
    logic [2:0]        btn_q;
    logic [DROP_W-1:0] drop_q;
    logic [7:0]        byte_sel;
    logic              wr;

    // tx_full comes from a register inside the UART, so gating it
    // combinationally here does not create a loop.
    assign wr        = (state_q == SEND) && !tx_full_i;
    assign wr_uart_o = wr;
    assign busy_o    = (state_q == SEND);
    assign w_data_o  = (state_q == SEND) ? byte_sel : 8'h00;
    assign drop_cnt_o = drop_q;

    // Line FSM: latch a packet in IDLE, then step through the bytes of the
    // line on every accepted write.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            btn_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m_done_tick_i) begin
                        x_q     <= xm_i;
                        y_q     <= ym_i;
                        btn_q   <= btnm_i;
                        idx_q   <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (idx_q > LAST_IDX) begin
                        // Index values past the end of the line should never
                        // occur; recover by going back to IDLE.
                        idx_q   <= '0;
                        state_q <= IDLE;
                    end else if (wr) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    idx_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Count packets that arrive while a line is in flight.
    // The counter saturates at all-ones.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            drop_q <= '0;
        end else if ((state_q == SEND) && m_done_tick_i && (drop_q != {DROP_W{1'b1}})) begin
            drop_q <= drop_q + DROP_W'(1);
        end
    end

    // Select the byte for the current line position from the held packet.
    always_comb begin
        byte_sel = 8'h00;
        case (idx_q)
            4'd0:  byte_sel = btn_q[0] ? CH_L : CH_DASH;
            4'd1:  byte_sel = btn_q[2] ? CH_M : CH_DASH;
            4'd2:  byte_sel = btn_q[1] ? CH_R : CH_DASH;
            4'd3:  byte_sel = CH_SPACE;
            4'd4:  byte_sel = hex_ascii({3'b000, x_q[8]});
            4'd5:  byte_sel = hex_ascii(x_q[7:4]);
            4'd6:  byte_sel = hex_ascii(x_q[3:0]);
            4'd7:  byte_sel = CH_SPACE;
            4'd8:  byte_sel = hex_ascii({3'b000, y_q[8]});
            4'd9:  byte_sel = hex_ascii(y_q[7:4]);
            4'd10: byte_sel = hex_ascii(y_q[3:0]);
`ifdef MOUSE_FMT_CRLF_EN
            4'd11: byte_sel = CH_CR;
            4'd12: byte_sel = CH_LF;
`else
            4'd11: byte_sel = CH_LF;
`endif
            default: byte_sel = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_mouse_uart_fmt.sv
// Self-checking bench for mouse_uart_fmt.
// It uses fixed-vector lines, backpressure, drops with saturation,
// reset in the middle of a line, and randomized lines checked against a
// string-level model of the output line.
module tb_mouse_uart_fmt;

`ifdef MOUSE_FMT_CRLF_EN
    localparam int    LEN  = 13;
    localparam string TERM = "\r\n";
`else
    localparam int    LEN  = 12;
    localparam string TERM = "\n";
`endif

    logic       clk;
    logic       reset;
    logic [8:0] xm;
    logic [8:0] ym;
    logic [2:0] btnm;
    logic       m_done_tick;
    logic       tx_full;
    logic [7:0] w_data;
    logic       wr_uart;
    logic       busy;
    logic [7:0] drop_cnt;

    mouse_uart_fmt #(.DROP_W(8)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .xm_i         (xm),
        .ym_i         (ym),
        .btnm_i       (btnm),
        .m_done_tick_i(m_done_tick),
        .tx_full_i    (tx_full),
        .w_data_o     (w_data),
        .wr_uart_o    (wr_uart),
        .busy_o       (busy),
        .drop_cnt_o   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] x;
        logic [8:0] y;
        logic [2:0] b;
        string      txt;
    } vec_t;

    vec_t tbl[3];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   mdrop  = 0;

    // Render control characters visibly so that a FAIL line stays on one line.
    function automatic string esc(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s.getc(i) < 8'h20) r = $sformatf("%s<%02h>", r, s.getc(i));
            else                   r = $sformatf("%s%c", r, s.getc(i));
        end
        return r;
    endfunction

    // Reference line: built from the formatting rules at the string level.
    function automatic string model_line(input logic [8:0] x, input logic [8:0] y,
                                         input logic [2:0] b);
        string hx = $sformatf("%h", x);
        string hy = $sformatf("%h", y);
        return $sformatf("%s%s%s %s %s%s", b[0] ? "L" : "-", b[2] ? "M" : "-",
                         b[1] ? "R" : "-", hx.toupper(), hy.toupper(), TERM);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got \"%s\" expected \"%s\"", name, esc(act), esc(exp));
    endtask

    // Drive one packet tick. Call away from the rising edge; on return we
    // are just past the edge that accepted it, i.e. in cycle T+1.
    task automatic send_tick(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
        xm = x; ym = y; btnm = b; m_done_tick = 1'b1;
        @(posedge clk); #1;
        m_done_tick = 1'b0;
    endtask

    // Collect the bytes of one line. k counts busy cycles from T+1.
    // tx_full is high for k in [fs, fs+fl). A tick is issued on each k whose
    // bit is set in tmask. On return we are at the negedge of the first
    // non-busy cycle.
    task automatic capture(input int fs, input int fl, input int tmask, input bit hold_chk,
                           output string got, output int ncyc);
        got = ""; ncyc = 0;
        forever begin
            tx_full     = (ncyc >= fs) && (ncyc < fs + fl);
            m_done_tick = (ncyc < 32) ? tmask[ncyc] : 1'b0;
            if (m_done_tick) begin
                xm = 9'($urandom); ym = 9'($urandom); btnm = 3'($urandom);
            end
            @(negedge clk);
            if (!busy) begin
                tx_full = 1'b0; m_done_tick = 1'b0;
                break;
            end
            if (tx_full) begin
                chk("wr_blocked", {31'd0, wr_uart}, 32'd0);
                if (hold_chk) chk("hold_wdata", {24'd0, w_data}, 32'h20);
            end
            if (wr_uart) got = $sformatf("%s%c", got, w_data);
            ncyc++;
            if (ncyc > 200) begin
                n_chk++;
                $display("FAIL line_timeout: still busy after %0d cycles", ncyc);
                tx_full = 1'b0; m_done_tick = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        string got;
        int    n;
        int    raw;
        logic [8:0] rx, ry;
        logic [2:0] rb;
        int    fs, fl, tm;

        tbl[0] = '{9'h005, 9'h1FE, 3'b001, "L-- 005 1FE"};
        tbl[1] = '{9'h0FF, 9'h100, 3'b111, "LMR 0FF 100"};
        tbl[2] = '{9'h1A3, 9'h05C, 3'b110, "-MR 1A3 05C"};

        reset = 1'b0; xm = '0; ym = '0; btnm = '0; m_done_tick = 1'b0; tx_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr",   {31'd0, wr_uart}, 32'd0);
        chk("rst_busy", {31'd0, busy},    32'd0);
        chk("rst_wdata",{24'd0, w_data},  32'd0);
        chk("rst_drop", {24'd0, drop_cnt},32'd0);

        // A tick while reset is low must not be latched.
        m_done_tick = 1'b1; xm = 9'h123;
        @(posedge clk); #1;
        m_done_tick = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("rst_tick_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Table lines, back to back: each tick lands on the first idle cycle.
        for (int i = 0; i < 3; i++) begin
            send_tick(tbl[i].x, tbl[i].y, tbl[i].b);
            capture(0, 0, 0, 1'b0, got, n);
            chk_str($sformatf("line%0d", i), got, {tbl[i].txt, TERM});
            chk($sformatf("line%0d_cycles", i), n, LEN);
        end

        // Backpressure while byte 3 (space) is pending.
        send_tick(tbl[0].x, tbl[0].y, tbl[0].b);
        capture(3, 5, 0, 1'b1, got, n);
        chk_str("bp_line", got, {tbl[0].txt, TERM});
        chk("bp_cycles", n, LEN + 5);

        // Three drops, one on the final-byte cycle.
        send_tick(tbl[1].x, tbl[1].y, tbl[1].b);
        capture(0, 0, (1 << 2) | (1 << 6) | (1 << (LEN - 1)), 1'b0, got, n);
        chk_str("drop_line", got, {tbl[1].txt, TERM});
        chk("drop_cnt3", {24'd0, drop_cnt}, 32'd3);

        // Saturation: tick on every busy cycle until at least 300 drops.
        raw = 3;
        while (raw < 300) begin
            rx = 9'($urandom); ry = 9'($urandom); rb = 3'($urandom);
            send_tick(rx, ry, rb);
            capture(0, 0, (1 << LEN) - 1, 1'b0, got, n);
            raw += LEN;
            chk_str("sat_line", got, model_line(rx, ry, rb));
        end
        chk("drop_sat", {24'd0, drop_cnt}, 32'd255);

        // Reset after byte 6 has been written.
        send_tick(tbl[2].x, tbl[2].y, tbl[2].b);
        repeat (7) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_wr",    {31'd0, wr_uart}, 32'd0);
        chk("midrst_busy",  {31'd0, busy},    32'd0);
        chk("midrst_drop",  {24'd0, drop_cnt},32'd0);
        chk("midrst_wdata", {24'd0, w_data},  32'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        send_tick(tbl[2].x, tbl[2].y, tbl[2].b);
        capture(0, 0, 0, 1'b0, got, n);
        chk_str("midrst_fresh", got, {tbl[2].txt, TERM});
        mdrop = 0;

        // Random lines with random backpressure windows and drops.
        for (int i = 0; i < 20; i++) begin
            rx = 9'($urandom); ry = 9'($urandom); rb = 3'($urandom);
            fs = $urandom_range(0, LEN - 1);
            fl = $urandom_range(0, 6);
            tm = int'($urandom) & ((1 << LEN) - 1);
            send_tick(rx, ry, rb);
            capture(fs, fl, tm, 1'b0, got, n);
            mdrop += $countones(tm);
            chk_str("rnd_line", got, model_line(rx, ry, rb));
            chk("rnd_cycles", n, LEN + fl);
            chk("rnd_drop", {24'd0, drop_cnt}, (mdrop > 255) ? 255 : mdrop);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mouse_uart_fmt.md
# mouse_uart_fmt

Formats decoded PS/2 mouse packets into fixed-length ASCII text lines and writes them byte by byte into the `uart` transmit FIFO. It sits between the mouse packet decoder and `uart`:
- **Inputs:** `xm`, `ym`, `btnm` and `m_done_tick` from the mouse side.
- **Outputs:** `w_data` and `wr_uart` to `uart`, with `tx_full` as backpressure.

Packets that arrive while a line is still being sent are dropped and counted.

## Interface
- `DROP_W`, default 8: width of the saturating drop counter.
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `reset` input, 1 bit: synchronous, active-low reset.
- `xm` input, 9 bits: X movement, two's complement. Sampled on `m_done_tick`.
- `ym` input, 9 bits: Y movement, two's complement. Sampled on `m_done_tick`.
- `btnm` input, 3 bits: button bits. [0] left, [1] right, [2] middle.
- `m_done_tick` input, 1 bit: one-cycle pulse meaning a packet is valid.
- `tx_full` input, 1 bit: `uart` transmit FIFO full.
- `w_data` output, 8 bits: ASCII byte for `uart`.
- `wr_uart` output, 1 bit: write strobe to `uart`.
- `busy` output, 1 bit: high while a line is being sent.
- `drop_cnt` output, `DROP_W` bits: number of packets dropped. Saturates at all-ones.

## Operation
- **Line format, 13 bytes, index 0..12:**
  - 0: `L` if `btnm[0]`, else `-`.
  - 1: `M` if `btnm[2]`, else `-`.
  - 2: `R` if `btnm[1]`, else `-`.
  - 3: space (0x20).
  - 4..6: X as 3 uppercase hex digits. The first digit is bit 8, so it is `0` or `1`; then bits 7:4, then bits 3:0.
  - 7: space.
  - 8..10: Y, same encoding as X.
  - 11: CR (0x0D).
  - 12: LF (0x0A).
- **Hex digits:** 0–9 map to 0x30–0x39. A–F map to 0x41–0x46.
- **FSM states:**
  - `IDLE`: on `m_done_tick`, latch `xm`, `ym` and `btnm` into holding registers, clear the byte index, go to `SEND`.
  - `SEND`: on each cycle with `wr_uart`, increment the index. After the write of the last byte (index 12), go to `IDLE`.
- **Write strobe:** `wr_uart = (state==SEND) && !tx_full`. This is combinational; `tx_full` is registered inside `uart`.
- **Data:** `w_data` is a mux from the holding registers and the byte index. It is valid whenever `state==SEND`.
- **Backpressure:** while `tx_full` is high, `wr_uart` stays 0. The index and `w_data` hold. There is no timeout.
- **Drops:** an `m_done_tick` while in `SEND` is dropped, including during the final-byte cycle. The holding registers are not disturbed. `drop_cnt` increments by 1 and stops at 2^`DROP_W`−1.
- **Busy:** `busy = (state==SEND)`.

## Timing
- **Reset values:** state `IDLE`, index 0, holding registers 0. `wr_uart`=0, `busy`=0, `w_data`=0x00, `drop_cnt`=0.
- **Reset mid-line:** at the next rising edge, all of the above reset values apply. The partial line is abandoned and no further bytes are written.
- **Latency:** with `m_done_tick` at cycle T, `busy` and the first `wr_uart` (byte `L`/`-`) appear at T+1.
- **Throughput without backpressure:** 13 consecutive `wr_uart` cycles, T+1..T+13. State is `IDLE` at T+14, and a tick at T+14 is accepted.
- **Simultaneous events:**
  - `tx_full` rising in the same cycle as a write: no effect on that write. The next write waits.
  - `m_done_tick` together with reset low: reset wins and nothing is latched.
- **Counter width:** the index is 4 bits. Values 13–15 are unreachable; if they occur, return to `IDLE`.

## Configuration
- `MOUSE_FMT_CRLF_EN`:
  - **Defined:** the line terminator is CR LF and the line is 13 bytes, as above.
  - **Undefined:** CR is omitted. The line is 12 bytes ending in LF at index 11, and the final index and all timing shift by one cycle. For example, `IDLE` returns at T+13.

## Structure
- **Package `mouse_fmt_pkg`:**
  - Constants: `CH_SPACE`, `CH_CR`, `CH_LF`, `CH_DASH`, `CH_L`, `CH_M`, `CH_R`.
  - `LINE_LEN`, selected by the macro.
  - Function `hex_ascii(4-bit) -> 8-bit`.
  - State enum `{IDLE, SEND}`.
- **Sub-module:** none. The formatter is one FSM plus a byte mux, and hex conversion uses the package function.

## Test plan
- **Basic line:** reset, then `xm`=9'h005, `ym`=9'h1FE, `btnm`=3'b001, tick. Expect bytes "L-- 005 1FE\r\n" (13 bytes) on cycles T+1..T+13 and `busy` low at T+14.
- **All buttons, max values:** `btnm`=3'b111, `xm`=9'h0FF, `ym`=9'h100. Expect "LMR 0FF 100\r\n".
- **Backpressure:** `tx_full` held high for 5 cycles after byte 3. Expect no `wr_uart` in that window, `w_data`=0x20 held throughout, and all 13 bytes still delivered in order.
- **Drops:** 3 ticks during `SEND`, including one on the final-byte cycle. Expect `drop_cnt`=3 and the line content unchanged. Then force 300 drops with `DROP_W`=8; expect `drop_cnt`=255.
- **Reset mid-line:** reset low after byte 6. At the next edge expect `wr_uart`=0, `busy`=0, `drop_cnt`=0. A new tick then yields a complete fresh line.
- **Macro undefined:** same stimulus as the basic line. Expect "L-- 005 1FE\n" (12 bytes) and `busy` low at T+13.
